// File: rtl/ramp_pkg.sv
// Ramp sequencer shared definitions: ramper state codes, sequencer state encoding, legality helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ramp_pkg;

  // Width of one ramper's reported state code
  localparam int RS_W = 3;

  typedef logic [RS_W-1:0] ramp_code_t;

  // Ramper-reported state codes; 5..7 are never produced by a healthy ramper
  localparam ramp_code_t RS_RAMP_UP   = 3'd0;
  localparam ramp_code_t RS_NORMAL    = 3'd1;
  localparam ramp_code_t RS_REQ_DOWN  = 3'd2;
  localparam ramp_code_t RS_RAMP_DOWN = 3'd3;
  localparam ramp_code_t RS_DONE      = 3'd4;

  // Sequencer state encoding, visible to software through seq_state
  typedef logic [2:0] seq_state_t;

  localparam seq_state_t SEQ_IDLE     = 3'd0;
  localparam seq_state_t SEQ_RAMP_UP  = 3'd1;
  localparam seq_state_t SEQ_RUNNING  = 3'd2;
  localparam seq_state_t SEQ_REQ_DOWN = 3'd3;
  localparam seq_state_t SEQ_DONE     = 3'd4;
  localparam seq_state_t SEQ_ERROR    = 3'd5;

  function automatic logic is_illegal_ramp_state(input ramp_code_t code);
    return (code > RS_DONE);
  endfunction

endpackage

// File: rtl/ramp_sequencer_if.sv
// Bundle between ramp sequencer, the register file (cfg/cmd/status) and the ramper array.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle pulses, status is level.
// slave  = sequencer side: takes cfg/cmd/ramp_state_i, drives ramper controls and status.
// master = register file + rampers side.
interface ramp_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 32
);
  logic [NUM_CH-1:0]   cfg_enable_ramping;
  logic [TMO_W-1:0]    cfg_timeout;
  logic                cmd_start;
  logic                cmd_stop;
  logic                cmd_clear;
  logic [3*NUM_CH-1:0] ramp_state_i;
  logic                ramper_resetn;
  logic [NUM_CH-1:0]   enable_ramping;
  logic                start_ramp_down;
  logic [2:0]          seq_state;
  logic                busy;
  logic                done;
  logic                error;

  modport slave (
    input  cfg_enable_ramping, cfg_timeout, cmd_start, cmd_stop, cmd_clear, ramp_state_i,
    output ramper_resetn, enable_ramping, start_ramp_down, seq_state, busy, done, error
  );

  modport master (
    output cfg_enable_ramping, cfg_timeout, cmd_start, cmd_stop, cmd_clear, ramp_state_i,
    input  ramper_resetn, enable_ramping, start_ramp_down, seq_state, busy, done, error
  );
endinterface

// File: rtl/ramp_state_reduce.sv
// Reduces per-channel ramper states under an enable mask to all_up / all_done / any_illegal.
// Latency: combinational.
// Backpressure: none.
// Ports: ramp_state_i (3 bits per channel), mask (enabled channels) -> all_up, all_done, any_illegal.
module ramp_state_reduce
  import ramp_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [3*NUM_CH-1:0] ramp_state_i,
  input  logic [NUM_CH-1:0]   mask,
  output logic                all_up,
  output logic                all_done,
  output logic                any_illegal
);

  ramp_code_t code;

  // Masked-off channels never block a condition, so an empty mask gives all_up/all_done true
  always_comb begin
    all_up      = 1'b1;
    all_done    = 1'b1;
    any_illegal = 1'b0;
    code        = RS_RAMP_UP;
    for (int k = 0; k < NUM_CH; k++) begin
      code = ramp_state_i[3*k +: 3];
      if (mask[k]) begin
        if (code == RS_RAMP_UP || is_illegal_ramp_state(code)) all_up = 1'b0;
        if (code != RS_DONE) all_done = 1'b0;
        if (is_illegal_ramp_state(code)) any_illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// Sequences the DAC rampers through ramp-up / run / ramp-down on start/stop, with per-phase timeout.
// Latency: outputs registered, reflect a state change one cycle after the deciding input.
// Backpressure: none; commands are pulses, ignored in states where they have no meaning.
// Ports: clk, aresetn, bus (slave modport: cfg/cmd/ramp_state_i in; ramper controls and status out).
module ramp_sequencer
  import ramp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 32
) (
  input logic            clk,
  input logic            aresetn,
  ramp_sequencer_if.slave bus
);

  localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  seq_state_t        state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              pend_q, pend_d;
  logic              all_up, all_done, any_illegal, tmo_hit;

  ramp_state_reduce #(.NUM_CH(NUM_CH)) u_reduce (
    .ramp_state_i (bus.ramp_state_i),
    .mask         (mask_q),
    .all_up       (all_up),
    .all_done     (all_done),
    .any_illegal  (any_illegal)
  );

  // Saturating increment: a stuck phase with timeout disabled must not wrap
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  // Counter starts at 0 on phase entry, so cnt == timeout-1 marks the timeout-th cycle
  assign tmo_hit = (bus.cfg_timeout != '0) && (cnt_q == bus.cfg_timeout - CNT_ONE);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (state_q != SEQ_IDLE && any_illegal) begin
      // A ramper reporting garbage overrides everything else
      state_d = SEQ_ERROR;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (bus.cmd_start) begin
            state_d = SEQ_RAMP_UP;
            mask_d  = bus.cfg_enable_ramping;
            cnt_d   = '0;
            pend_d  = bus.cmd_stop;
          end
        end
        SEQ_RAMP_UP: begin
          if (bus.cmd_stop) pend_d = 1'b1;
          if (all_up) begin
            state_d = SEQ_RUNNING;
            cnt_d   = '0;
          end else if (tmo_hit) begin
            state_d = SEQ_ERROR;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        SEQ_RUNNING: begin
          cnt_d = '0;
          // A stop seen during ramp-up is honoured on the first RUNNING cycle
          if (bus.cmd_stop || pend_q) begin
            state_d = SEQ_REQ_DOWN;
            pend_d  = 1'b0;
          end
        end
        SEQ_REQ_DOWN: begin
          if (all_done) begin
            state_d = SEQ_DONE;
          end else if (tmo_hit) begin
            state_d = SEQ_ERROR;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        SEQ_DONE, SEQ_ERROR: begin
          if (bus.cmd_clear) state_d = SEQ_IDLE;
        end
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q             <= SEQ_IDLE;
      mask_q              <= '0;
      cnt_q               <= '0;
      pend_q              <= 1'b0;
      bus.ramper_resetn   <= 1'b0;
      bus.start_ramp_down <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.error           <= 1'b0;
    end else begin
      state_q             <= state_d;
      mask_q              <= mask_d;
      cnt_q               <= cnt_d;
      pend_q              <= pend_d;
      // Decoded from next state so they line up with seq_state
      bus.ramper_resetn   <= (state_d != SEQ_IDLE);
      bus.start_ramp_down <= (state_d inside {SEQ_REQ_DOWN, SEQ_DONE, SEQ_ERROR});
      bus.busy            <= (state_d inside {SEQ_RAMP_UP, SEQ_RUNNING, SEQ_REQ_DOWN});
      bus.done            <= (state_d == SEQ_DONE);
      bus.error           <= (state_d == SEQ_ERROR);
    end
  end

  assign bus.seq_state      = state_q;
  assign bus.enable_ramping = mask_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Randomized bench for ramp_sequencer: a cycle model predicts state transitions into a queue,
// a monitor pops and compares whenever seq_state changes.
// Ports driven through ramp_sequencer_if; clock 10 ns.
module tb_ramp_sequencer;
  localparam int NUM_CH = 4;
  localparam int TMO_W  = 32;

  logic clk;
  logic aresetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int               st;
    int               cyc;
    logic [NUM_CH-1:0] mask;
  } exp_t;

  exp_t q[$];

  // Reference model state: phase named by the sequencer code, time spent in the timed phase
  int                m_state = 0;
  logic [NUM_CH-1:0] m_mask  = '0;
  bit                m_pend  = 0;
  longint            m_phase = 0;

  ramp_sequencer_if #(.NUM_CH(NUM_CH), .TMO_W(TMO_W)) bus ();

  ramp_sequencer #(.NUM_CH(NUM_CH), .TMO_W(TMO_W)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // {ramper_resetn, start_ramp_down, busy, done, error} for a given sequencer state
  function automatic logic [4:0] exp_flags(input int st);
    return {st != 0, st >= 3, (st >= 1 && st <= 3), st == 4, st == 5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Predict what the next rising edge does given the inputs currently applied
  task automatic model_step();
    bit up, dn, ill;
    int nxt;
    if (!aresetn) return;
    up = 1; dn = 1; ill = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_mask[k]) begin
        int c;
        c = int'(bus.ramp_state_i[3*k +: 3]);
        if (c > 4) ill = 1;
        if (c < 1 || c > 4) up = 0;
        if (c != 4) dn = 0;
      end
    end
    nxt = m_state;
    if (m_state != 0 && ill) begin
      nxt = 5;
      m_pend = 0;
    end else begin
      case (m_state)
        0: if (bus.cmd_start) begin
             nxt = 1; m_mask = bus.cfg_enable_ramping; m_phase = 0; m_pend = bus.cmd_stop;
           end
        1: begin
             if (bus.cmd_stop) m_pend = 1;
             m_phase++;
             if (up) nxt = 2;
             else if (bus.cfg_timeout != 0 && m_phase == longint'(bus.cfg_timeout)) begin
               nxt = 5; m_pend = 0;
             end
           end
        2: if (bus.cmd_stop || m_pend) begin
             nxt = 3; m_pend = 0; m_phase = 0;
           end
        3: begin
             m_phase++;
             if (dn) nxt = 4;
             else if (bus.cfg_timeout != 0 && m_phase == longint'(bus.cfg_timeout)) nxt = 5;
           end
        default: if (bus.cmd_clear) nxt = 0;
      endcase
    end
    if (nxt != m_state) q.push_back('{nxt, cyc + 1, m_mask});
    m_state = nxt;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
      bus.cmd_start = 1'b0;
      bus.cmd_stop  = 1'b0;
      bus.cmd_clear = 1'b0;
    end
  endtask

  task automatic set_ch(input int k, input logic [2:0] code);
    bus.ramp_state_i[3*k +: 3] = code;
  endtask

  task automatic set_all(input logic [2:0] code);
    for (int k = 0; k < NUM_CH; k++) set_ch(k, code);
  endtask

  // Channels in 'who' move from c_from to c_to at random times; the last one lands on tick len
  task automatic phase(input logic [NUM_CH-1:0] who, input logic [2:0] c_from,
                       input logic [2:0] c_to, input int len);
    int thr[NUM_CH];
    int j;
    for (int k = 0; k < NUM_CH; k++) thr[k] = $urandom_range(1, len);
    if (who != '0) begin
      do j = $urandom_range(0, NUM_CH - 1); while (!who[j]);
      thr[j] = len;
    end
    for (int i = 1; i <= len; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        if (who[k]) set_ch(k, (i >= thr[k]) ? c_to : c_from);
      tick(1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seq_state"}, 32'(bus.seq_state), 0);
    chk({tag, "_ramper_resetn"}, 32'(bus.ramper_resetn), 0);
    chk({tag, "_start_ramp_down"}, 32'(bus.start_ramp_down), 0);
    chk({tag, "_enable_ramping"}, 32'(bus.enable_ramping), 0);
    chk({tag, "_status"}, 32'({bus.busy, bus.done, bus.error}), 0);
  endtask

  // Monitor: every change of seq_state must match the next predicted transition
  initial begin
    logic [2:0] prev;
    exp_t       e;
    logic [4:0] act;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (bus.seq_state !== prev) begin
        prev = bus.seq_state;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: seq_state=%0d at cycle %0d, none predicted",
                   bus.seq_state, cyc);
        end else begin
          e = q.pop_front();
          if (int'(bus.seq_state) != e.st || cyc != e.cyc) begin
            errors++;
            $display("FAIL transition: seq_state=%0d at cycle %0d, expected %0d at cycle %0d",
                     bus.seq_state, cyc, e.st, e.cyc);
          end
          act = {bus.ramper_resetn, bus.start_ramp_down, bus.busy, bus.done, bus.error};
          checks++;
          if (act !== exp_flags(e.st)) begin
            errors++;
            $display("FAIL outputs_state%0d: {resetn,srd,busy,done,error}=%b, expected %b at cycle %0d",
                     e.st, act, exp_flags(e.st), cyc);
          end
          if (e.st != 0) begin
            checks++;
            if (bus.enable_ramping !== e.mask) begin
              errors++;
              $display("FAIL enable_ramping: got %b, expected %b at cycle %0d",
                       bus.enable_ramping, e.mask, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int j, len;
    logic [NUM_CH-1:0] m;
    aresetn = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.cfg_enable_ramping = '0;
    bus.cfg_timeout = '0;
    bus.ramp_state_i = '0;
    #1 aresetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    tick(2);

    // Normal full cycle, all channels, no timeout; start in DONE is ignored
    bus.cfg_enable_ramping = 4'hF; bus.cfg_timeout = 0; set_all(3'd0);
    bus.cmd_start = 1'b1; tick(1);
    phase(4'hF, 3'd0, 3'd1, 100);
    tick(99);
    bus.cmd_stop = 1'b1; bus.cfg_enable_ramping = 4'h3; tick(1);
    phase(4'hF, 3'd3, 3'd4, 300);
    tick(3);
    bus.cmd_start = 1'b1; tick(3);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(3);

    // Mask 0101: channels 1/3 stuck at RAMP_UP, then an illegal code on a masked-off channel
    bus.cfg_enable_ramping = 4'b0101; bus.cfg_timeout = 1000;
    bus.cmd_start = 1'b1; tick(1);
    phase(4'b0101, 3'd0, 3'd1, $urandom_range(5, 40));
    tick(3);
    set_ch(1, 3'd7); tick(3);
    bus.cmd_stop = 1'b1; tick(1);
    phase(4'b0101, 3'd3, 3'd4, $urandom_range(5, 40));
    tick(2);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Empty mask: RUNNING two cycles after start, DONE right after REQ_DOWN
    bus.cfg_enable_ramping = '0; bus.cfg_timeout = 0;
    bus.cmd_start = 1'b1; tick(4);
    bus.cmd_stop = 1'b1; tick(4);
    bus.cmd_clear = 1'b1; tick(3);

    // Stop during RAMP_UP
    bus.cfg_enable_ramping = 4'hF;
    bus.cmd_start = 1'b1; tick(1);
    tick($urandom_range(1, 5));
    bus.cmd_stop = 1'b1;
    phase(4'hF, 3'd0, 3'd1, $urandom_range(3, 20));
    tick(3);
    phase(4'hF, 3'd3, 3'd4, $urandom_range(3, 20));
    tick(1);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Start and stop in the same cycle
    bus.cmd_start = 1'b1; bus.cmd_stop = 1'b1; tick(1);
    phase(4'hF, 3'd0, 3'd1, $urandom_range(3, 20));
    tick(2);
    phase(4'hF, 3'd3, 3'd4, $urandom_range(3, 20));
    tick(1);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Ramp-up timeout: channel 2 never leaves RAMP_UP; commands other than clear ignored in ERROR
    bus.cfg_timeout = 50;
    bus.cmd_start = 1'b1; tick(1);
    phase(4'b1011, 3'd0, 3'd1, 30);
    tick(25);
    bus.cmd_start = 1'b1; tick(1);
    bus.cmd_stop = 1'b1; tick(2);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // all_up on the 50th RAMP_UP cycle beats the timeout; then REQ_DOWN timeout at 20
    bus.cmd_start = 1'b1; tick(1);
    phase(4'hF, 3'd0, 3'd1, 50);
    tick(2);
    bus.cfg_timeout = 20;
    bus.cmd_stop = 1'b1; tick(1);
    tick(25);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Illegal code on an enabled channel while RUNNING
    m = NUM_CH'($urandom_range(1, 15)); bus.cfg_enable_ramping = m; bus.cfg_timeout = 0;
    bus.cmd_start = 1'b1; tick(1);
    phase(m, 3'd0, 3'd1, $urandom_range(3, 15));
    tick(3);
    do j = $urandom_range(0, NUM_CH - 1); while (!m[j]);
    set_ch(j, 3'd6); tick(3);
    set_ch(j, 3'd1);
    bus.cmd_start = 1'b1; tick(2);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Asynchronous reset in the middle of REQ_DOWN, then a fresh sequence
    bus.cfg_enable_ramping = 4'hF;
    bus.cmd_start = 1'b1; tick(1);
    phase(4'hF, 3'd0, 3'd1, 10);
    tick(2);
    bus.cmd_stop = 1'b1; tick(1);
    set_all(3'd3); tick(5);
    q.push_back('{0, cyc + 1, '0});
    m_state = 0; m_mask = '0; m_pend = 0; m_phase = 0;
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    tick(2);
    aresetn = 1'b1;
    set_all(3'd0); tick(1);
    bus.cfg_enable_ramping = 4'b0011;
    bus.cmd_start = 1'b1; tick(1);
    phase(4'b0011, 3'd0, 3'd1, 10);
    bus.cmd_stop = 1'b1; tick(1);
    phase(4'b0011, 3'd3, 3'd4, 10);
    bus.cmd_clear = 1'b1; tick(1);
    set_all(3'd0); tick(2);

    // Random full cycles
    for (int r = 0; r < 4; r++) begin
      m = NUM_CH'($urandom_range(1, 15));
      bus.cfg_enable_ramping = m;
      bus.cfg_timeout = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'd200;
      bus.cmd_start = 1'b1; bus.cmd_stop = 1'($urandom_range(0, 1)); tick(1);
      len = $urandom_range(2, 30);
      phase(m, 3'd0, 3'd1, len);
      tick($urandom_range(1, 10));
      bus.cmd_stop = 1'b1; tick(1);
      phase(m, 3'd3, 3'd4, $urandom_range(2, 30));
      tick(2);
      bus.cmd_clear = 1'b1; tick(1);
      set_all(3'd0); tick(2);
    end

    tick(5);
    chk("pending_predictions", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
